// File: rtl/ir_assembler.sv
// rtl/ir_assembler.sv - multi-beat instruction register with atomic word update
// Beats are staged until the final one arrives; ir then loads the whole word at once.
module ir_assembler #(
   parameter int BUS_W     = 8,
   parameter int BEATS     = 2,
   parameter int OPC_W     = 3,
   parameter int MSB_FIRST = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ena,
   input  logic [BUS_W-1:0]             data,
   output logic [BUS_W*BEATS-1:0]       ir,
   output logic [OPC_W-1:0]             opc,
   output logic [BUS_W*BEATS-OPC_W-1:0] iraddr,
   output logic                         ir_valid,
   output logic                         busy,
   output logic                         abort
);

   localparam int IR_W  = BUS_W * BEATS;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [IR_W-1:0]  BEAT_ONES = IR_W'({BUS_W{1'b1}});

   logic [CNT_W-1:0] r_cnt;
   logic [IR_W-1:0]  r_stg;
   logic [IR_W-1:0]  r_ir;
   logic             r_ir_valid;
   logic             r_abort;

   int               w_lsb;
   logic [IR_W-1:0]  w_mask;
   logic [IR_W-1:0]  w_merged;

   // Current beat's slot, expressed as a shift so one datapath serves both orders.
   always_comb begin
      w_lsb = 0;
      if (MSB_FIRST != 0) begin
         w_lsb = IR_W - (int'(r_cnt) + 1) * BUS_W;
      end else begin
         w_lsb = int'(r_cnt) * BUS_W;
      end
      w_mask   = BEAT_ONES << w_lsb;
      w_merged = (r_stg & ~w_mask) | (IR_W'(data) << w_lsb);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_stg      <= '0;
         r_ir       <= '0;
         r_ir_valid <= 1'b0;
         r_abort    <= 1'b0;
      end else if (ena) begin
         r_abort <= 1'b0;
         if (r_cnt == LAST_BEAT) begin
            r_ir       <= w_merged;
            r_ir_valid <= 1'b1;
            r_cnt      <= '0;
            r_stg      <= '0;
         end else begin
            r_stg <= w_merged;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == '0) begin
               r_ir_valid <= 1'b0;
            end
         end
      end else if (r_cnt != '0) begin
         // Gap inside a fetch: drop the partial word, ir keeps its last good value.
         r_cnt   <= '0;
         r_stg   <= '0;
         r_abort <= 1'b1;
      end else begin
         r_abort <= 1'b0;
      end
   end

   assign ir       = r_ir;
   assign opc      = r_ir[IR_W-1 -: OPC_W];
   assign iraddr   = r_ir[IR_W-OPC_W-1:0];
   assign ir_valid = r_ir_valid;
   assign busy     = (r_cnt != '0);
   assign abort    = r_abort;

endmodule

// File: tb/tb_ir_assembler.sv
// tb/tb_ir_assembler.sv - scoreboard bench for ir_assembler over four parameter sets
// All instances have a 16-bit ir; expected state is queued per edge and checked by a monitor.
module tb_ir_assembler;

   logic        clk;
   logic        rst;
   logic [3:0]  en;
   logic [7:0]  d0, d1;
   logic [3:0]  d2;
   logic [15:0] d3;

   logic [15:0] ir0, ir1, ir2, ir3;
   logic [2:0]  opc0, opc1, opc3;
   logic [3:0]  opc2;
   logic [12:0] ad0, ad1, ad3;
   logic [11:0] ad2;
   logic [3:0]  vld, bsy, abt;

   ir_assembler #(.BUS_W(8), .BEATS(2), .OPC_W(3), .MSB_FIRST(1)) u0 (
      .clk(clk), .rst(rst), .ena(en[0]), .data(d0), .ir(ir0), .opc(opc0), .iraddr(ad0),
      .ir_valid(vld[0]), .busy(bsy[0]), .abort(abt[0]));
   ir_assembler #(.BUS_W(8), .BEATS(2), .OPC_W(3), .MSB_FIRST(0)) u1 (
      .clk(clk), .rst(rst), .ena(en[1]), .data(d1), .ir(ir1), .opc(opc1), .iraddr(ad1),
      .ir_valid(vld[1]), .busy(bsy[1]), .abort(abt[1]));
   ir_assembler #(.BUS_W(4), .BEATS(4), .OPC_W(4), .MSB_FIRST(1)) u2 (
      .clk(clk), .rst(rst), .ena(en[2]), .data(d2), .ir(ir2), .opc(opc2), .iraddr(ad2),
      .ir_valid(vld[2]), .busy(bsy[2]), .abort(abt[2]));
   ir_assembler #(.BUS_W(16), .BEATS(1), .OPC_W(3), .MSB_FIRST(1)) u3 (
      .clk(clk), .rst(rst), .ena(en[3]), .data(d3), .ir(ir3), .opc(opc3), .iraddr(ad3),
      .ir_valid(vld[3]), .busy(bsy[3]), .abort(abt[3]));

   typedef struct packed {
      logic [3:0][15:0] ir;
      logic [3:0]       v;
      logic [3:0]       b;
      logic [3:0]       a;
   } snap_t;

   snap_t       exp_q[$];
   snap_t       s;
   int          n_vec = 0;
   int          n_bad = 0;

   int unsigned m_acc[4];
   int          m_cnt[4];
   logic [15:0] m_ir[4];
   logic        m_v[4];
   logic        m_ab[4];

   logic [15:0] act_ir[4];
   logic [3:0]  act_opc[4];
   logic [12:0] act_ad[4];

   always_comb begin
      act_ir[0] = ir0;  act_ir[1] = ir1;  act_ir[2] = ir2;  act_ir[3] = ir3;
      act_opc[0] = {1'b0, opc0}; act_opc[1] = {1'b0, opc1};
      act_opc[2] = opc2;         act_opc[3] = {1'b0, opc3};
      act_ad[0] = ad0; act_ad[1] = ad1; act_ad[2] = {1'b0, ad2}; act_ad[3] = ad3;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int bus_w(input int i);
      return (i == 2) ? 4 : (i == 3) ? 16 : 8;
   endfunction
   function automatic int beats(input int i);
      return (i == 2) ? 4 : (i == 3) ? 1 : 2;
   endfunction

   // Word built arithmetically: MSB-first is a radix-2^BUS_W number, LSB-first a weighted sum.
   task automatic model_step(input int i, input logic r, input logic e, input int unsigned dv);
      if (!r) begin
         m_cnt[i] = 0; m_acc[i] = 0; m_ir[i] = '0; m_v[i] = 1'b0; m_ab[i] = 1'b0;
      end else if (e) begin
         if (m_cnt[i] == 0) m_acc[i] = 0;
         if (i != 1) m_acc[i] = m_acc[i] * (32'd1 << bus_w(i)) + dv;
         else        m_acc[i] = m_acc[i] + (dv << (m_cnt[i] * bus_w(i)));
         m_cnt[i] = m_cnt[i] + 1;
         m_ab[i]  = 1'b0;
         if (m_cnt[i] == beats(i)) begin
            m_ir[i] = 16'(m_acc[i]); m_v[i] = 1'b1; m_cnt[i] = 0;
         end else if (m_cnt[i] == 1) begin
            m_v[i] = 1'b0;
         end
      end else begin
         m_ab[i]  = (m_cnt[i] != 0);
         m_cnt[i] = 0;
      end
   endtask

   task automatic cycle(input logic r, input logic [3:0] e,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
      snap_t t;
      rst = r; en = e; d0 = a[7:0]; d1 = b[7:0]; d2 = c[3:0]; d3 = d;
      model_step(0, r, e[0], {24'd0, a[7:0]});
      model_step(1, r, e[1], {24'd0, b[7:0]});
      model_step(2, r, e[2], {28'd0, c[3:0]});
      model_step(3, r, e[3], {16'd0, d});
      for (int i = 0; i < 4; i++) begin
         t.ir[i] = m_ir[i]; t.v[i] = m_v[i]; t.b[i] = (m_cnt[i] != 0); t.a[i] = m_ab[i];
      end
      exp_q.push_back(t);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   always begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         for (int i = 0; i < 4; i++) begin
            logic [3:0]  eo;
            logic [12:0] ea;
            eo = (i == 2) ? s.ir[i][15:12] : {1'b0, s.ir[i][15:13]};
            ea = (i == 2) ? {1'b0, s.ir[i][11:0]} : s.ir[i][12:0];
            n_vec++;
            if (act_ir[i] !== s.ir[i] || vld[i] !== s.v[i] || bsy[i] !== s.b[i] ||
                abt[i] !== s.a[i] || act_opc[i] !== eo || act_ad[i] !== ea) begin
               n_bad++;
               $display("FAIL u%0d state @%0t: ir=%h/%h valid=%b/%b busy=%b/%b abort=%b/%b opc=%h/%h iraddr=%h/%h (got/expected)",
                        i, $time, act_ir[i], s.ir[i], vld[i], s.v[i], bsy[i], s.b[i],
                        abt[i], s.a[i], act_opc[i], eo, act_ad[i], ea);
            end
         end
      end
   end

   initial begin
      rst = 1'b0; en = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      @(negedge clk);
      cycle(0, 4'b0000, 0, 0, 0, 0);
      cycle(0, 4'b0000, 0, 0, 0, 0);
      chk("reset_ir", ir0, 16'h0000);
      chk("reset_flags", {13'd0, vld[0], bsy[0], abt[0]}, 16'h0000);

      cycle(1, 4'b1111, 16'hA5, 16'h3C, 16'hD, 16'hBEEF);
      chk("b1_ir", ir3, 16'hBEEF);
      cycle(1, 4'b1111, 16'h3C, 16'hA5, 16'hE, 16'h0001);
      chk("msb_ir", ir0, 16'hA53C);
      chk("msb_opc", {13'd0, opc0}, 16'h0005);
      chk("msb_iraddr", {3'd0, ad0}, 16'h053C);
      chk("msb_valid_busy", {14'd0, vld[0], bsy[0]}, 16'h0002);
      chk("lsb_ir", ir1, 16'hA53C);
      chk("b1_ir2", {ir3[14:0], vld[3]}, 16'h0003);

      cycle(1, 4'b0101, 16'h11, 0, 16'hA, 0);
      chk("partial", {ir0[12:0], vld[0], bsy[0], abt[0]}, {16'hA53C, 3'b010} >> 3 << 3 | 16'h0002);
      cycle(1, 4'b0100, 0, 0, 16'hD, 0);
      chk("abort_pulse", {13'd0, abt[0], bsy[0], vld[0]}, 16'h0004);
      chk("abort_ir", ir0, 16'hA53C);
      chk("dead_ir", ir2, 16'hDEAD);
      cycle(1, 4'b0101, 16'h11, 0, 16'h1, 0);
      chk("abort_clear", {15'd0, abt[0]}, 16'h0000);
      chk("b2b_hold", {ir2[14:0], vld[2]}, {16'hDEAD << 1} & 16'hFFFE);
      cycle(1, 4'b0101, 16'h22, 0, 16'h2, 0);
      chk("after_abort_ir", ir0, 16'h1122);
      cycle(1, 4'b0100, 0, 0, 16'h3, 0);
      cycle(1, 4'b0100, 0, 0, 16'h4, 0);
      chk("second_ir", ir2, 16'h1234);
      chk("second_opc_addr", {opc2, ad2}, 16'h1234);

      cycle(1, 4'b0001, 16'h77, 0, 0, 0);
      cycle(0, 4'b0001, 16'h88, 0, 0, 0);
      chk("rst_mid", {ir0[12:0], vld[0], bsy[0], abt[0]}, 16'h0000);
      cycle(1, 4'b0001, 16'h12, 0, 0, 0);
      cycle(1, 4'b0001, 16'h34, 0, 0, 0);
      chk("rst_mid_next", ir0, 16'h1234);

      for (int k = 0; k < 3000; k++) begin
         logic [3:0] e;
         for (int i = 0; i < 4; i++) e[i] = ($urandom_range(0, 3) != 0);
         cycle(($urandom_range(0, 63) != 0), e, 16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom));
      end

      cycle(1, 4'b0000, 0, 0, 0, 0);
      cycle(1, 4'b0000, 0, 0, 0, 0);
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
      #5;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
